// File: rtl/mul_mod128_reduce_pkg.sv
// Shared MulMod definitions: operand widths, reducer FSM states and the
// inverted-N helper used by the 65-bit compare-subtract datapath.
package mulmod_pkg;

    localparam int P_WIDTH  = 64;
    localparam int PD_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // r - N is computed as r + ninv65(N) + 1; carry-out set means r >= N.
    function automatic logic [P_WIDTH:0] ninv65(input logic [P_WIDTH-1:0] n);
        return ~{1'b0, n};
    endfunction

endpackage

// File: rtl/mul_mod128_reduce_csub_step.sv
// One restoring shift-subtract step: shift the next product bit into r,
// then subtract N when the shifted remainder is not below N.
module mulmod_csub_step #(
    parameter int P_WIDTH = 64
) (
    input  logic [P_WIDTH:0]   i_r,
    input  logic               i_bit,
    input  logic [P_WIDTH-1:0] i_n,
    input  logic [P_WIDTH:0]   i_ninv,
    output logic [P_WIDTH:0]   o_r
);

    logic [P_WIDTH:0]   w_sh;
    logic [P_WIDTH+1:0] w_sum;
    logic               w_ge;
    logic               w_unused_msb;

    // r < N on entry, so the 65th bit is always zero and drops out of the shift.
    assign w_unused_msb = i_r[P_WIDTH];
    assign w_sh         = {i_r[P_WIDTH-1:0], i_bit};
    assign w_sum        = {1'b0, w_sh} + {1'b0, i_ninv} + {{(P_WIDTH+1){1'b0}}, 1'b1};
    assign w_ge         = w_sum[P_WIDTH+1];
    assign o_r          = w_ge ? (w_sh - {1'b0, i_n}) : w_sh;

endmodule

// File: rtl/mul_mod128_reduce.sv
// Sequential 128-by-64 modular reducer, MSB-first restoring division with
// BPC chained compare-subtract steps per clock and ready/valid on both sides.
module mul_mod128_reduce #(
    parameter int P_WIDTH  = mulmod_pkg::P_WIDTH,
    parameter int PD_WIDTH = mulmod_pkg::PD_WIDTH,
    parameter int BPC      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PD_WIDTH-1:0] mul_in,
    input  logic [P_WIDTH-1:0]  n_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_WIDTH-1:0]  res_out,
    output logic                err_out,
    output logic                busy
);

    import mulmod_pkg::state_t;
    import mulmod_pkg::ninv65;

    localparam int STEPS = PD_WIDTH / BPC;
    localparam int CNT_W = $clog2(STEPS);

    state_t                  r_state;
    logic [PD_WIDTH-1:0]     r_d;
    logic [P_WIDTH-1:0]      r_n;
    logic [P_WIDTH:0]        r_r;
    logic [CNT_W-1:0]        r_cnt;
    logic [P_WIDTH-1:0]      r_res;
    logic                    r_err;

    logic [P_WIDTH:0]        w_ninv;
    logic [BPC:0][P_WIDTH:0] w_chain;

    assign w_ninv     = ninv65(r_n);
    assign w_chain[0] = r_r;

    for (genvar g = 0; g < BPC; g++) begin : g_step
        mulmod_csub_step #(.P_WIDTH(P_WIDTH)) u_step (
            .i_r    (w_chain[g]),
            .i_bit  (r_d[PD_WIDTH-1-g]),
            .i_n    (r_n),
            .i_ninv (w_ninv),
            .o_r    (w_chain[g+1])
        );
    end

    // Handshake outputs decode state only, so no input reaches an output combinationally.
    assign in_ready  = (r_state == mulmod_pkg::IDLE);
    assign out_valid = (r_state == mulmod_pkg::DONE);
    assign busy      = (r_state != mulmod_pkg::IDLE);
    assign res_out   = r_res;
    assign err_out   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= mulmod_pkg::IDLE;
            r_d     <= '0;
            r_n     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                mulmod_pkg::IDLE: begin
                    if (in_valid) begin
                        r_d   <= mul_in;
                        r_n   <= n_in;
                        r_r   <= '0;
                        r_cnt <= '0;
                        if (n_in == '0) begin
                            r_res   <= '0;
                            r_err   <= 1'b1;
                            r_state <= mulmod_pkg::DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= mulmod_pkg::RUN;
                        end
                    end
                end
                mulmod_pkg::RUN: begin
                    r_r   <= w_chain[BPC];
                    r_d   <= {r_d[PD_WIDTH-BPC-1:0], {BPC{1'b0}}};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(STEPS - 1)) begin
                        r_res   <= w_chain[BPC][P_WIDTH-1:0];
                        r_state <= mulmod_pkg::DONE;
                    end
                end
                mulmod_pkg::DONE: begin
                    if (out_ready) r_state <= mulmod_pkg::IDLE;
                end
                default: r_state <= mulmod_pkg::IDLE;
            endcase
        end
    end

endmodule
